// File: rtl/int_alu_pkg.sv
// Shared definitions for the serial integer ALU blocks: FSM state encoding
// and a counter-width helper.
package int_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    // Width needed to count nchunk slices; never narrower than one bit so a
    // single-chunk configuration still has a legal counter.
    function automatic int cnt_width(input int nchunk);
        int w;
        w = $clog2(nchunk);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/int_sub_chunk.sv
// Combinational CHUNK_WIDTH-bit subtract with borrow in and borrow out.
module int_sub_chunk
    import int_alu_pkg::*;
#(
    parameter int CHUNK_WIDTH = 8
) (
    input  logic [CHUNK_WIDTH-1:0] a,
    input  logic [CHUNK_WIDTH-1:0] b,
    input  logic                   borrow_in,
    output logic [CHUNK_WIDTH-1:0] diff,
    output logic                   borrow_out
);

    logic [CHUNK_WIDTH:0] full_s;

    // Extend by one bit so the top bit of the result is the borrow.
    always_comb begin
        full_s     = {1'b0, a} - {1'b0, b} - {{CHUNK_WIDTH{1'b0}}, borrow_in};
        diff       = full_s[CHUNK_WIDTH-1:0];
        borrow_out = full_s[CHUNK_WIDTH];
    end

endmodule

// File: rtl/int_sub_serial.sv
// Multi-cycle subtractor: diff = data_a - data_b - borrow_in, one chunk per
// cycle with a rippled borrow, behind valid/ready handshakes on both sides.
module int_sub_serial
    import int_alu_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  borrow_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] diff,
    output logic                  borrow_out,
    output logic                  overflow
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    generate
        if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_width
            $error("int_sub_serial: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
        end
    endgenerate

    sub_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  borrow_q, borrow_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  a_msb_q, a_msb_d;
    logic                  b_msb_q, b_msb_d;
    logic [DATA_WIDTH-1:0] diff_q, diff_d;
    logic                  borrow_out_q, borrow_out_d;
    logic                  overflow_q, overflow_d;

    logic [CHUNK_WIDTH-1:0] chunk_diff_s;
    logic                   chunk_borrow_s;
    logic [DATA_WIDTH-1:0]  res_shift_s;

    int_sub_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
        .a          (a_q[CHUNK_WIDTH-1:0]),
        .b          (b_q[CHUNK_WIDTH-1:0]),
        .borrow_in  (borrow_q),
        .diff       (chunk_diff_s),
        .borrow_out (chunk_borrow_s)
    );

    // New chunk enters the result from the top so after NCHUNK steps the
    // lowest chunk has reached bit 0; written as shift/or so NCHUNK=1 works.
    always_comb begin
        res_shift_s = (res_q >> CHUNK_WIDTH)
                    | (DATA_WIDTH'(chunk_diff_s) << (DATA_WIDTH - CHUNK_WIDTH));
    end

    // Next-state and datapath control for IDLE/BUSY/DONE.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = data_a;
                    b_d      = data_b;
                    borrow_d = borrow_in;
                    a_msb_d  = data_a[DATA_WIDTH-1];
                    b_msb_d  = data_b[DATA_WIDTH-1];
                    cnt_d    = {CNT_W{1'b0}};
                    res_d    = {DATA_WIDTH{1'b0}};
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BUSY: begin
                a_d      = a_q >> CHUNK_WIDTH;
                b_d      = b_q >> CHUNK_WIDTH;
                borrow_d = chunk_borrow_s;
                res_d    = res_shift_s;
                if (cnt_q == CNT_LAST) begin
                    diff_d       = res_shift_s;
                    borrow_out_d = chunk_borrow_s;
                    overflow_d   = (a_msb_q != b_msb_q)
                                && (res_shift_s[DATA_WIDTH-1] != a_msb_q);
                    state_d      = ST_DONE;
                end else begin
                    cnt_d        = cnt_q + CNT_W'(1);
                    state_d      = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand, counter and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= {DATA_WIDTH{1'b0}};
            b_q          <= {DATA_WIDTH{1'b0}};
            borrow_q     <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            res_q        <= {DATA_WIDTH{1'b0}};
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            diff_q       <= {DATA_WIDTH{1'b0}};
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
        end
    end

    // Handshake flags decode the state register only; results come from flops.
    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_int_sub_serial.sv
// Self-checking bench for int_sub_serial: transaction-level reference model,
// per-cycle compare process, directed corner cases and randomized traffic.
module tb_int_sub_serial;

    localparam int DW     = 32;
    localparam int CWID   = 8;
    localparam int NCHUNK = DW / CWID;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic          borrow_in = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] diff;
    logic          borrow_out;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    int_sub_serial #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CWID)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_a     (data_a),
        .data_b     (data_b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference result straight from the arithmetic definition:
    // {overflow, borrow_out, diff}.
    function automatic logic [DW+1:0] ref_sub(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic bi);
        logic [DW:0]   full;
        logic [DW-1:0] d;
        logic          ov;
        full = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, bi};
        d    = full[DW-1:0];
        ov   = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
        return {ov, full[DW], d};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one operation in flight, result visible NCHUNK edges
    // after acceptance, held until the next completion, cleared by reset.
    logic          m_live = 1'b0;
    logic          m_busy = 1'b0;
    int            m_age  = 0;
    logic [DW+1:0] m_pend = '0;
    logic [DW+1:0] m_out  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_live <= 1'b1;
            m_busy <= 1'b0;
            m_age  <= 0;
            m_out  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_pend <= ref_sub(data_a, data_b, borrow_in);
            end
        end else if (m_age < NCHUNK) begin
            m_age <= m_age + 1;
            if (m_age == NCHUNK - 1) m_out <= m_pend;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",   {31'd0, in_ready},   {31'd0, !m_busy});
            check("out_valid",  {31'd0, out_valid},  {31'd0, (m_busy && m_age == NCHUNK)});
            check("diff",       diff,                m_out[DW-1:0]);
            check("borrow_out", {31'd0, borrow_out}, {31'd0, m_out[DW]});
            check("overflow",   {31'd0, overflow},   {31'd0, m_out[DW+1]});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Present operands and complete the input handshake (bounded wait).
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bi);
        int t;
        t = 0;
        data_a = a; data_b = b; borrow_in = bi; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) check("send_timeout", 32'(t), 32'd0);
        step();
        in_valid = 1'b0;
    endtask

    // Count cycles from the handshake until out_valid (bounded).
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) check("valid_timeout", 32'(k), 32'd0);
    endtask

    task automatic directed(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic bi, input logic [DW-1:0] ed, input logic eb, input logic eo);
        int k;
        out_ready = 1'b1;
        send(a, b, bi);
        wait_valid(k);
        check({name, "_latency"}, 32'(k), 32'd4);
        check({name, "_diff"}, diff, ed);
        check({name, "_borrow"}, {31'd0, borrow_out}, {31'd0, eb});
        check({name, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        step();
        check({name, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [DW-1:0] corner [6] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_00FF};

    function automatic logic [DW-1:0] pick();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        else return $urandom();
    endfunction

    initial begin
        int k;
        logic [DW-1:0] held;

        repeat (2) step();
        rst = 1'b0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff",      diff,               32'd0);
        check("rst_borrow",    {31'd0, borrow_out}, 32'd0);

        directed("basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        directed("wrap",   32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        directed("sovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        directed("bin",    32'h0000_0100, 32'h0000_00FF, 1'b1, 32'h0000_0000, 1'b0, 1'b0);

        // Backpressure with ignored operand pulses during BUSY and DONE.
        out_ready = 1'b0;
        send(32'h1234_5678, 32'h0000_0678, 1'b0);
        data_a = 32'hDEAD_BEEF; data_b = 32'h1111_1111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_valid(k);
        held = diff;
        check("bp_diff", diff, 32'h1234_5000);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            data_a = $urandom(); data_b = $urandom();
            step();
            check("bp_stable", diff, held);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_hold_after", diff, 32'h1234_5000);

        // Reset during the second BUSY cycle aborts the operation.
        send(32'h0000_0010, 32'h0000_0001, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_idle",  {31'd0, in_ready},  32'd1);
        check("rstmid_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_diff",  diff,               32'd0);
        directed("after_rst", 32'd7, 32'd9, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);

        // Randomized traffic: random valid, operands and backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            data_a    = pick();
            data_b    = pick();
            borrow_in = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            if (c % 700 == 350) rst = 1'b1;
            else rst = 1'b0;
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_sub_serial.md
# int_sub_serial

Multi-cycle unsigned/two's-complement subtractor for the integer ALU, the inverse-operation counterpart of the registered adder. It computes `diff = data_a - data_b - borrow_in`, working on one CHUNK_WIDTH slice per cycle with a rippled borrow. Operands enter and results leave through valid/ready handshakes, so the block can sit between an issue stage and a writeback stage that apply backpressure.

## Interface
- `DATA_WIDTH`, 32: operand and result width; must be a multiple of CHUNK_WIDTH.
- `CHUNK_WIDTH`, 8: bits subtracted per cycle.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operands and borrow_in are valid.
- `in_ready`  output  1  block can accept operands.
- `data_a`  input  DATA_WIDTH  minuend.
- `data_b`  input  DATA_WIDTH  subtrahend.
- `borrow_in`  input  1  borrow into bit 0.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts result.
- `diff`  output  DATA_WIDTH  difference, modulo 2^DATA_WIDTH.
- `borrow_out`  output  1  1 when unsigned `data_a < data_b + borrow_in`.
- `overflow`  output  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- NCHUNK = DATA_WIDTH/CHUNK_WIDTH.
- The FSM has three states: IDLE, BUSY and DONE.
  - IDLE: `in_ready=1`. On `in_valid`, capture `data_a`, `data_b` and `borrow_in`. Clear the chunk counter, then go to BUSY.
  - BUSY: each cycle, subtract the lowest remaining chunk: `{b, d} = {0,a_c} - {0,b_c} - borrow`. Shift `d` into the result register from the top and shift the operands right by CHUNK_WIDTH. Store `b` as the next borrow. When counter == NCHUNK-1, load `diff`, `borrow_out` and `overflow` from the final values, then go to DONE.
  - DONE: `out_valid=1`. Go to IDLE when `out_ready=1`.
- `in_ready` is 0 in BUSY and DONE. `in_valid` in those states is ignored; no operand is captured.
- `overflow` is computed from the captured operand MSBs (held) and the final diff MSB.
- `diff`, `borrow_out` and `overflow` change only at the BUSY→DONE transition. They hold their value through IDLE until the next completion. They are stable while `out_valid && !out_ready`.
- Reset values: state IDLE, `in_ready=1` (combinational from state), `out_valid=0`, `diff=0`, `borrow_out=0`, `overflow=0`. Internal operand, borrow and counter registers are all 0.
- Reset mid-operation (BUSY or DONE): the operation is aborted and the result is discarded. All outputs take their reset values on the next edge.
- NCHUNK=1 is legal: BUSY lasts exactly one cycle.

## Timing
- Input handshake at edge T (IDLE, `in_valid=1`). BUSY occupies edges T+1..T+NCHUNK. `out_valid` goes high after edge T+NCHUNK. Defaults give 4 cycles of latency.
- Output handshake at edge U (`out_valid && out_ready`). `in_ready` is high after U. The next input handshake can happen at U+1.
- Throughput is one operation per NCHUNK+2 cycles at best. No back-to-back overlap.
- `out_ready` asserted before `out_valid` has no effect. If it is high on entering DONE, DONE lasts exactly one cycle.
- `in_ready` and `out_valid` are decoded from the state register only, with no input→output combinational path.

## Structure
- Package `int_alu_pkg`:
  - FSM state encoding (IDLE/BUSY/DONE localparams or enum).
  - Helper function for counter width, `$clog2(NCHUNK)`, with a minimum of 1.
- Sub-module `int_sub_chunk`: combinational CHUNK_WIDTH-bit subtract with borrow.
  - Ports: a, b, borrow_in, diff, borrow_out.
  - Instantiated once; the top holds the FSM, shift registers and output registers.
- Include an elaboration-time check that DATA_WIDTH % CHUNK_WIDTH == 0.

## Test plan
- Basic: a=0x00000005, b=0x00000003, borrow_in=0.
  - diff=0x00000002, borrow_out=0, overflow=0.
  - `out_valid` exactly 4 cycles after the input handshake.
- Wrap: a=0x00000000, b=0x00000001, borrow_in=0.
  - diff=0xFFFFFFFF, borrow_out=1, overflow=0.
- Signed overflow: a=0x80000000, b=0x00000001.
  - diff=0x7FFFFFFF, borrow_out=0, overflow=1.
- Borrow-in across chunks: a=0x00000100, b=0x000000FF, borrow_in=1.
  - diff=0x00000000, borrow_out=0, overflow=0.
- Backpressure and ignored input:
  - Hold `out_ready=0` for 5 cycles after `out_valid`; outputs stay stable and `in_ready=0`.
  - Pulse `in_valid` with new operands during BUSY and DONE; they are never captured.
  - Release `out_ready`; IDLE is reached next cycle.
- Reset mid-op: assert `rst` for one cycle during the second BUSY cycle.
  - Next cycle: IDLE, `out_valid=0`, `diff=0`.
  - A fresh operation (a=7, b=9) then gives diff=0xFFFFFFFE and borrow_out=1.
